node_slot_allocator: RTL and testbench
======================================

# node_slot_allocator

Registered free-slot allocator for the linked-list node memory. It tracks the occupancy of DEPTH node slots in a bitmap and grants one free slot per cycle, chosen by a priority scan. It accepts one slot release per cycle and reports full, empty and occupancy count. It sits between the list controller (insert/delete) and the node RAM, replacing the purely combinational first-one position detection with a stateful, handshaked allocator.

## Interface
- DEPTH, 16, number of node slots; power of two, ≥ 2.
- MSB_FIRST, 1, scan order:
  - 1: prefer the highest-numbered free slot.
  - 0: prefer the lowest-numbered free slot.
- AW, $clog2(DEPTH), derived index width; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req_i  in  1  request one slot this cycle.
- alloc_gnt_o  out  1  one-cycle pulse: grant for the request of the previous cycle.
- alloc_idx_o  out  AW  granted slot index; valid while alloc_gnt_o=1.
- alloc_nack_o  out  1  one-cycle pulse: the request of the previous cycle was refused because the allocator was full.
- free_vld_i  in  1  release the slot on free_idx_i.
- free_idx_i  in  AW  slot index to release.
- flush_i  in  1  synchronous clear of all slots.
- full_o  out  1  all slots used (registered).
- empty_o  out  1  no slots used (registered).
- count_o  out  AW+1  number of used slots, 0..DEPTH.
- err_dblfree_o  out  1  one-cycle pulse: the previous cycle freed a slot that was already free.

## Operation
- State:
  - used[DEPTH-1:0] occupancy bitmap.
  - count register.
  - Output registers for gnt, idx, nack and err.
  - No FSM beyond this.
- Candidate selection is combinational from the registered used[]:
  - MSB_FIRST=1: candidate is the highest i with used[i]=0.
  - MSB_FIRST=0: candidate is the lowest such i.
  - Slot index equals bit index.
- Allocation (alloc_req_i=1, flush_i=0):
  - If full_o=0: set used[candidate]; next cycle alloc_gnt_o=1 and alloc_idx_o=candidate.
  - If full_o=1: no state change; next cycle alloc_nack_o=1.
- Free (free_vld_i=1, flush_i=0):
  - If used[free_idx_i]=1: clear it.
  - Otherwise: no state change; next cycle err_dblfree_o=1.
- Simultaneous alloc and free in the same cycle:
  - Allocation uses the pre-update bitmap, so a slot being freed is not grantable this cycle.
  - If the allocator is full, the request is nacked even while a free is in progress.
  - Count net change is 0 when both succeed.
- Flush (flush_i=1):
  - Next state: used=0, count=0.
  - Same-cycle alloc_req_i and free_vld_i are ignored: no gnt, nack or err pulse.
- count_o, full_o and empty_o are registered and consistent with used[] after every edge:
  - full_o = (count==DEPTH).
  - empty_o = (count==0).
- alloc_idx_o holds its last granted value when alloc_gnt_o=0.

## Timing
- Reset (async assert, values held until the first edge after deassert):
  - used=0, count_o=0, empty_o=1, full_o=0.
  - alloc_gnt_o=0, alloc_idx_o=0, alloc_nack_o=0, err_dblfree_o=0.
- Latency: request in cycle N gives gnt or nack in cycle N+1. Error pulse also appears in N+1.
- Throughput:
  - One grant per cycle, back-to-back, with distinct indices guaranteed.
  - One free per cycle.
- A freed slot becomes grantable to a request in the cycle after the free.
- full_o, empty_o and count_o reflect an alloc or free issued in cycle N during cycle N+1.
- No combinational path from any input to any output.
- Reset asserted mid-operation: all state clears immediately and pending pulses are lost.

## Test plan
- Reset, then DEPTH=16, MSB_FIRST=1, hold alloc_req_i for 17 cycles:
  - Grants 15,14,…,0 on consecutive cycles.
  - 17th request gives alloc_nack_o=1.
  - full_o=1, count_o=16.
- MSB_FIRST=0, 3 requests: grants 0,1,2. Free 1, then request: grant 1. Next request: grant 3.
- Full allocator, alloc_req_i and free_vld_i (idx 5) in the same cycle:
  - Next cycle: nack=1, count_o=15.
  - Following request: grant 5, count_o=16.
- Free idx 7 while slot 7 is already free:
  - err_dblfree_o pulses one cycle.
  - count_o and used[] are unchanged.
- Allocate 4 slots, then flush_i together with alloc_req_i:
  - No gnt and no nack.
  - count_o=0, empty_o=1.
  - Next request grants the first slot in scan order (15 for MSB_FIRST=1).
- Assert rst asynchronously mid-stream with alloc_gnt_o=1:
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, the first grant is the initial scan-order slot.

Source files
------------

// File: rtl/node_slot_allocator.sv
// node_slot_allocator: bitmap-based free-slot allocator for the linked-list node memory.
// Grants one free slot per cycle by priority scan, accepts one release per cycle,
// and reports registered full/empty/occupancy status.
module node_slot_allocator #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req_i,
    output logic          alloc_gnt_o,
    output logic [AW-1:0] alloc_idx_o,
    output logic          alloc_nack_o,
    input  logic          free_vld_i,
    input  logic [AW-1:0] free_idx_i,
    input  logic          flush_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          err_dblfree_o
);

    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0] used;
    logic [DEPTH-1:0] used_nxt;
    logic [AW-1:0]    cand;
    logic             alloc_ok;
    logic             nack_nxt;
    logic             free_hit;
    logic             free_ok;
    logic             err_nxt;
    logic [AW:0]      count_nxt;

    // Priority scan of the registered bitmap; the last match in loop order wins.
    always_comb begin
        cand = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!used[i]) cand = AW'(i);
            end
        end else begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (!used[i]) cand = AW'(i);
            end
        end
    end

    // Next bitmap and count; allocation sees the pre-update bitmap, so a slot
    // being released this cycle is never the candidate.
    always_comb begin
        alloc_ok  = alloc_req_i && !full_o;
        nack_nxt  = alloc_req_i && full_o;
        free_hit  = used[free_idx_i];
        free_ok   = free_vld_i && free_hit;
        err_nxt   = free_vld_i && !free_hit;
        used_nxt  = used;
        if (alloc_ok) used_nxt[cand] = 1'b1;
        if (free_ok)  used_nxt[free_idx_i] = 1'b0;
        count_nxt = count_o + CW'(alloc_ok) - CW'(free_ok);
    end

    // State and registered outputs; flush clears occupancy and suppresses all pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used          <= '0;
            count_o       <= '0;
            full_o        <= 1'b0;
            empty_o       <= 1'b1;
            alloc_gnt_o   <= 1'b0;
            alloc_idx_o   <= '0;
            alloc_nack_o  <= 1'b0;
            err_dblfree_o <= 1'b0;
        end else if (flush_i) begin
            used          <= '0;
            count_o       <= '0;
            full_o        <= 1'b0;
            empty_o       <= 1'b1;
            alloc_gnt_o   <= 1'b0;
            alloc_nack_o  <= 1'b0;
            err_dblfree_o <= 1'b0;
        end else begin
            used          <= used_nxt;
            count_o       <= count_nxt;
            full_o        <= (count_nxt == CW'(DEPTH));
            empty_o       <= (count_nxt == '0);
            alloc_gnt_o   <= alloc_ok;
            alloc_nack_o  <= nack_nxt;
            err_dblfree_o <= err_nxt;
            if (alloc_ok) alloc_idx_o <= cand;
        end
    end

endmodule

// File: tb/tb_node_slot_allocator.sv
// Scoreboard bench for node_slot_allocator: one MSB-first and one LSB-first instance.
module tb_node_slot_allocator;

    typedef struct {
        int         cyc;
        logic       gnt;
        logic [3:0] idx;
        logic       nack;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req  [2];
    logic       fv   [2];
    logic [3:0] fidx [2];
    logic       fl   [2];
    logic       gnt  [2];
    logic [3:0] idx  [2];
    logic       nack [2];
    logic       err  [2];
    logic       full [2];
    logic       empty[2];
    logic [4:0] cnt  [2];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    node_slot_allocator #(.DEPTH(16), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst),
        .alloc_req_i(req[0]), .alloc_gnt_o(gnt[0]), .alloc_idx_o(idx[0]), .alloc_nack_o(nack[0]),
        .free_vld_i(fv[0]), .free_idx_i(fidx[0]), .flush_i(fl[0]),
        .full_o(full[0]), .empty_o(empty[0]), .count_o(cnt[0]), .err_dblfree_o(err[0])
    );

    node_slot_allocator #(.DEPTH(16), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .alloc_req_i(req[1]), .alloc_gnt_o(gnt[1]), .alloc_idx_o(idx[1]), .alloc_nack_o(nack[1]),
        .free_vld_i(fv[1]), .free_idx_i(fidx[1]), .flush_i(fl[1]),
        .full_o(full[1]), .empty_o(empty[1]), .count_o(cnt[1]), .err_dblfree_o(err[1])
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: pops the expectation due this cycle and compares the pulse outputs.
    task automatic mon(input int d);
        exp_t e;
        logic have;
        logic [6:0] got;
        logic [6:0] want;
        have = 1'b0;
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        got = {gnt[d], (gnt[d] ? idx[d] : 4'd0), nack[d], err[d]};
        if (have) begin
            checks++;
            want = {e.gnt, (e.gnt ? e.idx : 4'd0), e.nack, e.err};
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL dut%0d missed_resp: expected at cycle %0d, now %0d", d, e.cyc, cyc);
            end else if (got != want) begin
                errors++;
                $display("FAIL dut%0d resp cyc %0d: got gnt=%0b idx=%0d nack=%0b err=%0b expected gnt=%0b idx=%0d nack=%0b err=%0b",
                         d, cyc, got[6], got[5:2], got[1], got[0], want[6], want[5:2], want[1], want[0]);
            end
        end else if (gnt[d] || nack[d] || err[d]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_pulse cyc %0d: gnt=%0b idx=%0d nack=%0b err=%0b expected none",
                     d, cyc, gnt[d], idx[d], nack[d], err[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    // Drive one cycle on instance d and queue the response expected next cycle.
    task automatic drive(input int d, input logic r, input logic f, input logic [3:0] fi, input logic fls,
                         input logic eg, input logic [3:0] ei, input logic en, input logic ee);
        exp_t e;
        req[d] = r; fv[d] = f; fidx[d] = fi; fl[d] = fls;
        e.cyc = cyc + 1; e.gnt = eg; e.idx = ei; e.nack = en; e.err = ee;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        req[d] = 1'b0; fv[d] = 1'b0; fidx[d] = 4'd0; fl[d] = 1'b0;
    endtask

    task automatic chk_status(input int d, input string tag, input int c, input logic f, input logic em);
        chk({tag, "_count"}, int'(cnt[d]), c);
        chk({tag, "_full"},  int'(full[d]), int'(f));
        chk({tag, "_empty"}, int'(empty[d]), int'(em));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; fv[d] = 1'b0; fidx[d] = 4'd0; fl[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk_status(d, "reset", 0, 1'b0, 1'b1);
            chk("reset_gnt", int'(gnt[d]), 0);
            chk("reset_idx", int'(idx[d]), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // LSB-first: 0,1,2; free 1; regrant 1; then 3.
        drive(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk_status(1, "lsb3", 3, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("lsb_idx_hold", int'(idx[1]), 2);
        chk("lsb_free_count", int'(cnt[1]), 2);
        drive(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        chk_status(1, "lsb_end", 4, 1'b0, 1'b0);

        // MSB-first: fill with 15..0, then a nacked 17th request.
        for (int i = 0; i < 16; i++)
            drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'(15 - i), 1'b0, 1'b0);
        chk_status(0, "filled", 16, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_status(0, "nack17", 16, 1'b1, 1'b0);

        // Full: alloc and free 5 together -> nack; slot 5 grantable next cycle.
        drive(0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_status(0, "simul", 15, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        chk_status(0, "regrant5", 16, 1'b1, 1'b0);

        // Free 7, then free 7 again -> double-free pulse, count unchanged.
        drive(0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("free7_count", int'(cnt[0]), 15);
        drive(0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("dblfree_count", int'(cnt[0]), 15);
        drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        chk_status(0, "refill7", 16, 1'b1, 1'b0);

        // Flush, allocate 4, then flush together with a request.
        drive(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk_status(0, "flush1", 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'(15 - i), 1'b0, 1'b0);
        chk_status(0, "alloc4", 4, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk_status(0, "flush2", 0, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        chk("pre_rst_gnt", int'(gnt[0]), 1);

        // Asynchronous reset while the grant pulse is high.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_gnt", int'(gnt[0]), 0);
        chk("async_idx", int'(idx[0]), 0);
        chk_status(0, "async", 0, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        chk_status(0, "post_rst", 1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("q_drained", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
